// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults and types for the multiply-add arbiter slice.
//   MAC_N_REQ / MAC_DATA_WIDTH / MAC_OUT_WIDTH / MAC_ID_WIDTH : default sizes.
//   id_t          : requester tag at the default requester count.
//   pipe_stage_t  : view of one pipeline stage {valid, id, prod, c}.
package mac_pkg;

    localparam int MAC_N_REQ      = 4;
    localparam int MAC_DATA_WIDTH = 8;
    // a*b+c never exceeds 2^(2W)-2^W, so twice the operand width always holds it.
    localparam int MAC_OUT_WIDTH  = 2 * MAC_DATA_WIDTH;
    localparam int MAC_ID_WIDTH   = $clog2(MAC_N_REQ);

    typedef logic [MAC_ID_WIDTH-1:0] id_t;

    typedef struct packed {
        logic                     valid;
        id_t                      id;
        logic [MAC_OUT_WIDTH-1:0] prod;
        logic [MAC_OUT_WIDTH-1:0] c;
    } pipe_stage_t;

endpackage

// File: rtl/mac_pipe.sv
// mac_pipe: shared two-stage unsigned a*b+c unit.
//   clk, reset         : clock, synchronous active-high reset (valid bits only)
//   in_valid, in_id    : operation strobe and owner tag, carried alongside data
//   in_a, in_b, in_c   : unsigned operands
//   out_valid, out_id  : result strobe and owner tag, two cycles after input
//   out_data           : a*b+c (zero while out_valid is low)
//   busy               : any stage holds a valid operation
module mac_pipe
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = MAC_DATA_WIDTH,
    parameter int ID_WIDTH   = MAC_ID_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [ID_WIDTH-1:0]     in_id,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    input  logic [DATA_WIDTH-1:0]   in_c,
    output logic                    out_valid,
    output logic [ID_WIDTH-1:0]     out_id,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic                    busy
);

    localparam int OUT_WIDTH = 2 * DATA_WIDTH;

    logic                    vld_p1;
    logic [ID_WIDTH-1:0]     id_p1;
    logic [OUT_WIDTH-1:0]    prod_p1;
    logic [OUT_WIDTH-1:0]    c_p1;

    logic                    vld_p2;
    logic [ID_WIDTH-1:0]     id_p2;
    logic [OUT_WIDTH-1:0]    sum_p2;

    // Control: only the valid bits are reset, which discards in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
        end
    end

    // Stage 1: product and zero-extended addend
    always_ff @(posedge clk) begin
        id_p1   <= in_id;
        prod_p1 <= OUT_WIDTH'(in_a) * OUT_WIDTH'(in_b);
        c_p1    <= OUT_WIDTH'(in_c);
    end

    // Stage 2: final sum
    always_ff @(posedge clk) begin
        id_p2  <= id_p1;
        sum_p2 <= prod_p1 + c_p1;
    end

    // Data registers are not reset, so the outputs are qualified by valid
    // to present zeros after reset and between responses.
    assign out_valid = vld_p2;
    assign out_id    = vld_p2 ? id_p2  : '0;
    assign out_data  = vld_p2 ? sum_p2 : '0;
    assign busy      = vld_p1 | vld_p2;

endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin sharing of one pipelined a*b+c unit among N_REQ
// requesters; results return on one tagged response bus in issue order.
//   clk, reset              : clock, synchronous active-high reset
//   en                      : arbitration enable (in-flight work still drains)
//   req_valid               : per-requester request
//   req_a, req_b, req_c     : flattened operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready               : one-hot grant, combinational
//   resp_valid/id/data      : one-cycle result pulse, owner tag, a*b+c
//   busy                    : pipeline holds a valid operation
//   issue_count             : accepted operations, wraps modulo 2^16
module mac_arbiter
    import mac_pkg::*;
#(
    parameter int N_REQ      = MAC_N_REQ,
    parameter int DATA_WIDTH = MAC_DATA_WIDTH,
    parameter int ID_WIDTH   = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_c,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        resp_valid,
    output logic [ID_WIDTH-1:0]         resp_id,
    output logic [2*DATA_WIDTH-1:0]     resp_data,
    output logic                        busy,
    output logic [15:0]                 issue_count
);

    logic [ID_WIDTH-1:0]   last_ptr;
    logic [N_REQ-1:0]      grant;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic                  found;
    logic                  accept;
    int                    idx;
    logic [DATA_WIDTH-1:0] mux_a;
    logic [DATA_WIDTH-1:0] mux_b;
    logic [DATA_WIDTH-1:0] mux_c;

    // Search starts one past the last winner and wraps, so the most recent
    // winner is always considered last.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (en && !reset) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (int'(last_ptr) + k) % N_REQ;
                if (!found && req_valid[idx]) begin
                    found        = 1'b1;
                    grant[idx]   = 1'b1;
                    gnt_idx      = ID_WIDTH'(idx);
                end
            end
        end
    end

    assign req_ready = grant;
    assign accept    = found;

    // With no grant the mux still selects requester 0; in_valid masks it.
    assign mux_a = req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign mux_b = req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign mux_c = req_c[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Pointer starts at the top index so requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_ptr    <= ID_WIDTH'(N_REQ - 1);
            issue_count <= 16'd0;
        end else if (accept) begin
            last_ptr    <= gnt_idx;
            issue_count <= issue_count + 16'd1;
        end
    end

    mac_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_id     (gnt_idx),
        .in_a      (mux_a),
        .in_b      (mux_b),
        .in_c      (mux_c),
        .out_valid (resp_valid),
        .out_id    (resp_id),
        .out_data  (resp_data),
        .busy      (busy)
    );

endmodule

// File: tb/tb_mac_arbiter.sv
module tb_mac_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk;
    logic            reset;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*DW-1:0] req_c;
    logic [N-1:0]    req_ready;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [2*DW-1:0] resp_data;
    logic            busy;
    logic [15:0]     issue_count;

    mac_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_c       (req_c),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .busy        (busy),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ntot  = 0;
    int npass = 0;
    bit mon_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Scoreboard: expectation pushed at accept, compared when due.
    typedef struct {
        int id;
        int data;
        int due;
    } sb_t;
    sb_t sb[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                sb_t e;
                e = sb.pop_front();
                check("sb_resp_valid", 32'(resp_valid), 32'd1);
                check("sb_resp_id",    32'(resp_id),    32'(e.id));
                check("sb_resp_data",  32'(resp_data),  32'(e.data));
            end else if (resp_valid !== 1'b0) begin
                ntot++;
                $display("FAIL sb_unexpected_resp: got resp_valid=%b id=%0d data=%0d, expected none (cycle %0d)",
                         resp_valid, resp_id, resp_data, cyc);
            end
            if (reset) begin
                sb.delete();
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        sb_t n;
                        n.id   = i;
                        n.data = int'(req_a[i*DW +: DW]) * int'(req_b[i*DW +: DW]) + int'(req_c[i*DW +: DW]);
                        n.due  = cyc + 2;
                        sb.push_back(n);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int id, input int a, input int b, input int c);
        req_a[id*DW +: DW] = a[DW-1:0];
        req_b[id*DW +: DW] = b[DW-1:0];
        req_c[id*DW +: DW] = c[DW-1:0];
    endtask

    task automatic single_op(input int id, input int a, input int b, input int c,
                             input int exp, input string nm);
        bit got;
        int prev;
        step();
        set_ops(id, a, b, c);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 8 && !got; w++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
            else step();
        end
        check({nm, "_granted"}, 32'(got), 32'd1);
        if (!got) begin
            step();
            req_valid = '0;
            return;
        end
        prev = int'(issue_count);
        step();
        req_valid = '0;
        @(negedge clk);
        check({nm, "_count"}, 32'(issue_count), 32'((prev + 1) & 16'hFFFF));
        check({nm, "_busy_t1"}, 32'(busy), 32'd1);
        step();
        @(negedge clk);
        check({nm, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({nm, "_resp_id"},    32'(resp_id),    32'(id));
        check({nm, "_resp_data"},  32'(resp_data),  32'(exp));
        step();
        @(negedge clk);
        check({nm, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        int    id;
        int    a;
        int    b;
        int    c;
        int    exp;
        string nm;
    } vec_t;
    vec_t vecs[6];

    int c0;

    initial begin
        vecs[0] = '{0,   3,   4,   5,    17, "single_3x4p5"};
        vecs[1] = '{2, 255, 255, 255, 65280, "max_operands"};
        vecs[2] = '{1,   0,   0,   0,     0, "all_zero"};
        vecs[3] = '{0, 255,   0, 255,   255, "zero_mult"};
        vecs[4] = '{2,  16,  16,   1,   257, "carry_16x16p1"};
        vecs[5] = '{3, 200, 100,  50, 20050, "mixed_3"};

        reset     = 1'b1;
        en        = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        for (int i = 0; i < N; i++) set_ops(i, i + 1, i + 2, i + 3);

        // Reset held three cycles with every request raised
        step();
        mon_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check("rst_req_ready",   32'(req_ready),   32'd0);
            check("rst_resp_valid",  32'(resp_valid),  32'd0);
            check("rst_resp_id",     32'(resp_id),     32'd0);
            check("rst_resp_data",   32'(resp_data),   32'd0);
            check("rst_busy",        32'(busy),        32'd0);
            check("rst_issue_count", 32'(issue_count), 32'd0);
            step();
        end
        reset     = 1'b0;
        req_valid = '0;

        // Single operations from the table
        for (int v = 0; v < 6; v++)
            single_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].exp, vecs[v].nm);

        // Fairness: all requesters held; last winner was 3, so order starts at 0
        step();
        for (int i = 0; i < N; i++) set_ops(i, 17 * i + 3, 29 * i + 7, 11 * i + 1);
        req_valid = '1;
        c0 = int'(issue_count);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(1 << (k % N)));
            step();
            if (k == 7) req_valid = '0;
        end
        @(negedge clk);
        check("rr_issue_count", 32'(issue_count), 32'((c0 + 8) & 16'hFFFF));
        step();
        step();
        @(negedge clk);
        check("rr_drained_busy", 32'(busy), 32'd0);

        // Enable gating: two issues, then en low with req1 waiting
        step();
        c0 = int'(issue_count);
        set_ops(0, 9, 9, 9);
        set_ops(2, 12, 5, 3);
        set_ops(1, 100, 2, 1);
        req_valid = 4'b0001;
        @(negedge clk);
        check("en_grant_a", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b0100;
        @(negedge clk);
        check("en_grant_b", 32'(req_ready), 32'b0100);
        step();
        en        = 1'b0;
        req_valid = 4'b0010;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check("en_off_no_grant", 32'(req_ready), 32'd0);
            check("en_off_count", 32'(issue_count), 32'((c0 + 2) & 16'hFFFF));
            step();
        end
        en = 1'b1;
        @(negedge clk);
        check("en_back_grant_req1", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        step();
        @(negedge clk);
        check("en_drained_busy", 32'(busy), 32'd0);

        // Reset with two operations in flight
        step();
        set_ops(2, 250, 3, 7);
        set_ops(3, 77, 66, 55);
        req_valid = 4'b0100;
        @(negedge clk);
        check("mid_grant_2", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        check("mid_grant_3", 32'(req_ready), 32'b1000);
        step();
        reset     = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        check("mid_rst_busy_before", 32'(busy), 32'd1);
        check("mid_rst_no_grant", 32'(req_ready), 32'd0);
        step();
        reset     = 1'b0;
        req_valid = '0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            check("mid_post_resp_valid", 32'(resp_valid), 32'd0);
            check("mid_post_busy",       32'(busy),       32'd0);
            check("mid_post_count",      32'(issue_count), 32'd0);
            step();
        end
        set_ops(0, 5, 6, 7);
        set_ops(3, 8, 9, 10);
        req_valid = 4'b1001;
        @(negedge clk);
        check("mid_prio_req0", 32'(req_ready), 32'b0001);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        check("mid_then_req3", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        step();
        step();
        @(negedge clk);
        check("mid_final_busy", 32'(busy), 32'd0);
        check("mid_final_count", 32'(issue_count), 32'd2);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
